// File: rtl/ps2_line_buffer.sv
// PS/2 set-2 keyboard line buffer: prefix decode, ASCII mapping, right-aligned line edit, command commit.
// Optional typematic repeat suppression is enabled by defining PS2_REPEAT_SUPPRESS_EN.
module ps2_line_buffer #(
    parameter int DEPTH  = 4,
    parameter int CHAR_W = 8,
    parameter int CNT_W  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_valid,
    input  logic [7:0]              scan_code,
    input  logic                    cmd_ready,
    output logic                    cmd_valid,
    output logic [DEPTH*CHAR_W-1:0] cmd_data,
    output logic [CNT_W-1:0]        cmd_len,
    output logic [DEPTH*CHAR_W-1:0] line_data,
    output logic [CNT_W-1:0]        line_count,
    output logic                    overflow,
    output logic [7:0]              last_ascii
);

    localparam int LINE_W = DEPTH * CHAR_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        K_NONE  = 2'd0,
        K_CHAR  = 2'd1,
        K_BS    = 2'd2,
        K_ENTER = 2'd3
    } kind_t;

    function automatic logic [7:0] map_ascii(input logic [7:0] code);
        logic [7:0] a;
        case (code)
            8'h1C: a = 8'h41;  8'h32: a = 8'h42;  8'h21: a = 8'h43;  8'h23: a = 8'h44;
            8'h24: a = 8'h45;  8'h2B: a = 8'h46;  8'h34: a = 8'h47;  8'h33: a = 8'h48;
            8'h43: a = 8'h49;  8'h3B: a = 8'h4A;  8'h42: a = 8'h4B;  8'h4B: a = 8'h4C;
            8'h3A: a = 8'h4D;  8'h31: a = 8'h4E;  8'h44: a = 8'h4F;  8'h4D: a = 8'h50;
            8'h15: a = 8'h51;  8'h2D: a = 8'h52;  8'h1B: a = 8'h53;  8'h2C: a = 8'h54;
            8'h3C: a = 8'h55;  8'h2A: a = 8'h56;  8'h1D: a = 8'h57;  8'h22: a = 8'h58;
            8'h35: a = 8'h59;  8'h1A: a = 8'h5A;
            8'h45: a = 8'h30;  8'h16: a = 8'h31;  8'h1E: a = 8'h32;  8'h26: a = 8'h33;
            8'h25: a = 8'h34;  8'h2E: a = 8'h35;  8'h36: a = 8'h36;  8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;  8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    function automatic kind_t map_kind(input logic [7:0] code);
        kind_t k;
        case (code)
            8'h66:   k = K_BS;
            8'h5A:   k = K_ENTER;
            default: k = (map_ascii(code) != 8'h00) ? K_CHAR : K_NONE;
        endcase
        return k;
    endfunction

    state_t              state_r;
    logic [LINE_W-1:0]   line_r;
    logic [CNT_W-1:0]    count_r;
    logic                overflow_r;
    logic [7:0]          last_ascii_r;
    logic                cmd_valid_r;
    logic [LINE_W-1:0]   cmd_data_r;
    logic [CNT_W-1:0]    cmd_len_r;

    kind_t               kind_s;
    logic [7:0]          ascii_s;
    logic                make_s;
    logic                process_s;
    logic                slot_free_s;
    logic                commit_s;
    logic                char_s;
    logic                bs_s;

`ifdef PS2_REPEAT_SUPPRESS_EN
    logic [7:0]          last_make_r;
`endif

    // Classify the incoming byte and derive the single edit action for this cycle.
    always_comb begin
        kind_s      = map_kind(scan_code);
        ascii_s     = map_ascii(scan_code);
        slot_free_s = !cmd_valid_r || cmd_ready;
        if (scan_valid && (state_r == IDLE) && (scan_code != 8'hF0) && (scan_code != 8'hE0)) begin
            make_s = 1'b1;
        end else begin
            make_s = 1'b0;
        end
`ifdef PS2_REPEAT_SUPPRESS_EN
        if (make_s && (scan_code == last_make_r)) begin
            process_s = 1'b0;
        end else begin
            process_s = make_s;
        end
`else
        process_s = make_s;
`endif
        commit_s = process_s && (kind_s == K_ENTER) && (count_r != {CNT_W{1'b0}}) && slot_free_s;
        char_s   = process_s && (kind_s == K_CHAR);
        bs_s     = process_s && (kind_s == K_BS) && (count_r != {CNT_W{1'b0}});
    end

    // Prefix FSM, live edit buffer and output command slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            line_r       <= {LINE_W{1'b0}};
            count_r      <= {CNT_W{1'b0}};
            overflow_r   <= 1'b0;
            last_ascii_r <= 8'h00;
            cmd_valid_r  <= 1'b0;
            cmd_data_r   <= {LINE_W{1'b0}};
            cmd_len_r    <= {CNT_W{1'b0}};
        end else begin
            if (scan_valid) begin
                case (state_r)
                    IDLE: begin
                        if (scan_code == 8'hF0) begin
                            state_r <= BRK;
                        end else if (scan_code == 8'hE0) begin
                            state_r <= EXT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    BRK:     state_r <= IDLE;
                    EXT:     state_r <= (scan_code == 8'hF0) ? EXT_BRK : IDLE;
                    EXT_BRK: state_r <= IDLE;
                    default: state_r <= IDLE;
                endcase
            end else begin
                state_r <= state_r;
            end

            // A commit in the same cycle as an accept keeps the slot full with the new line.
            if (commit_s) begin
                cmd_valid_r <= 1'b1;
                cmd_data_r  <= line_r;
                cmd_len_r   <= count_r;
            end else if (cmd_valid_r && cmd_ready) begin
                cmd_valid_r <= 1'b0;
            end else begin
                cmd_valid_r <= cmd_valid_r;
            end

            if (commit_s) begin
                line_r     <= {LINE_W{1'b0}};
                count_r    <= {CNT_W{1'b0}};
                overflow_r <= 1'b0;
            end else if (char_s && (count_r < CNT_W'(DEPTH))) begin
                line_r       <= (line_r << CHAR_W) | LINE_W'(ascii_s);
                count_r      <= count_r + CNT_W'(1);
                last_ascii_r <= ascii_s;
            end else if (char_s) begin
                overflow_r <= 1'b1;
            end else if (bs_s) begin
                line_r  <= line_r >> CHAR_W;
                count_r <= count_r - CNT_W'(1);
            end else begin
                line_r <= line_r;
            end
        end
    end

`ifdef PS2_REPEAT_SUPPRESS_EN
    // Remember the last make code; its own break re-arms it.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_make_r <= 8'h00;
        end else if (make_s) begin
            last_make_r <= scan_code;
        end else if (scan_valid && (state_r == BRK) && (scan_code == last_make_r)) begin
            last_make_r <= 8'h00;
        end else begin
            last_make_r <= last_make_r;
        end
    end
`endif

    assign cmd_valid  = cmd_valid_r;
    assign cmd_data   = cmd_data_r;
    assign cmd_len    = cmd_len_r;
    assign line_data  = line_r;
    assign line_count = count_r;
    assign overflow   = overflow_r;
    assign last_ascii = last_ascii_r;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Scoreboard bench for ps2_line_buffer: directed scan sequences plus random bytes against a key-sequence model.
module tb_ps2_line_buffer;

    localparam int DEPTH  = 4;
    localparam int CHAR_W = 8;
    localparam int CNT_W  = 3;
    localparam int LW     = DEPTH * CHAR_W;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          scan_valid = 1'b0;
    logic [7:0]    scan_code = 8'h00;
    logic          cmd_ready = 1'b0;
    logic          cmd_valid;
    logic [LW-1:0] cmd_data;
    logic [CNT_W-1:0] cmd_len;
    logic [LW-1:0] line_data;
    logic [CNT_W-1:0] line_count;
    logic          overflow;
    logic [7:0]    last_ascii;

    ps2_line_buffer #(.DEPTH(DEPTH), .CHAR_W(CHAR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data), .cmd_len(cmd_len),
        .line_data(line_data), .line_count(line_count), .overflow(overflow), .last_ascii(last_ascii)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [LW-1:0] line;
        logic [CNT_W-1:0] cnt;
        logic        ovf;
        logic [7:0]  last;
        logic        cv;
    } exp_t;
    typedef struct {
        logic [LW-1:0] data;
        logic [CNT_W-1:0] len;
    } cmd_t;

    exp_t exp_q[$];
    cmd_t cmd_q[$];
    int n_checks = 0;
    int n_pass = 0;

    // Reference model: keystroke-level view of the line
    byte m_line[$];
    byte m_seq[$];
    bit  m_ovf;
    byte m_last;
    bit  m_pend;
    byte m_held;

    byte   codes[36] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,
                         8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,
                         8'h35,8'h1A,8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    function automatic int char_of(byte c);
        if (c == 8'h29) return 32;
        for (int i = 0; i < 36; i++) if (codes[i] == c) return int'(chars[i]);
        return -1;
    endfunction

    function automatic logic [LW-1:0] packed_line();
        logic [LW-1:0] v = '0;
        for (int i = 0; i < m_line.size(); i++) v = (v << 8) | LW'(m_line[i]);
        return v;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic push_exp();
        exp_t e;
        e.due = cyc + 1; e.line = packed_line(); e.cnt = CNT_W'(m_line.size());
        e.ovf = m_ovf; e.last = m_last; e.cv = m_pend;
        exp_q.push_back(e);
    endtask

    task automatic model_make(byte x, bit r, output bit commit);
        int ch;
        commit = 1'b0;
`ifdef PS2_REPEAT_SUPPRESS_EN
        if (x == m_held) return;
        m_held = x;
`endif
        ch = char_of(x);
        if (x == 8'h66) begin
            if (m_line.size() > 0) void'(m_line.pop_back());
        end else if (x == 8'h5A) begin
            if (m_line.size() > 0 && (!m_pend || r)) begin
                cmd_t c;
                c.data = packed_line(); c.len = CNT_W'(m_line.size());
                cmd_q.push_back(c);
                m_line.delete(); m_ovf = 1'b0; commit = 1'b1;
            end
        end else if (ch >= 0) begin
            if (m_line.size() < DEPTH) begin
                m_line.push_back(byte'(ch)); m_last = byte'(ch);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_step(bit v, byte b, bit r);
        bit acc = m_pend && r;
        bit commit = 1'b0;
        bit done = 1'b0;
        if (v) begin
            m_seq.push_back(b);
            if (m_seq[0] == 8'hF0) begin
                if (m_seq.size() == 2) begin
                    done = 1'b1;
`ifdef PS2_REPEAT_SUPPRESS_EN
                    if (m_held == m_seq[1]) m_held = 8'h00;
`endif
                end
            end else if (m_seq[0] == 8'hE0) begin
                done = (m_seq.size() == 3) || (m_seq.size() == 2 && m_seq[1] != 8'hF0);
            end else begin
                done = 1'b1;
                model_make(m_seq[0], r, commit);
            end
            if (done) m_seq.delete();
        end
        m_pend = commit ? 1'b1 : (acc ? 1'b0 : m_pend);
    endtask

    task automatic drive(bit v, byte b, bit r);
        @(posedge clk); #1;
        reset = 1'b0; scan_valid = v; scan_code = b; cmd_ready = r;
        model_step(v, b, r);
        push_exp();
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; scan_valid = 1'b1; scan_code = 8'h1C; cmd_ready = 1'b1;
        m_line.delete(); m_seq.delete(); cmd_q.delete();
        m_ovf = 0; m_last = 0; m_pend = 0; m_held = 0;
        push_exp();
    endtask

    task automatic press(byte c, bit r);
        drive(1'b1, c, r); drive(1'b1, 8'hF0, r); drive(1'b1, c, r);
    endtask

    // Monitor: compare scheduled state expectations and every command handed over.
    always @(negedge clk) begin
        exp_t e;
        cmd_t c;
        while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            e = exp_q.pop_front();
            check("line_data", 64'(line_data), 64'(e.line));
            check("line_count", 64'(line_count), 64'(e.cnt));
            check("overflow", 64'(overflow), 64'(e.ovf));
            check("last_ascii", 64'(last_ascii), 64'(e.last));
            check("cmd_valid", 64'(cmd_valid), 64'(e.cv));
        end
        if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && reset === 1'b0) begin
            if (cmd_q.size() == 0) begin
                check("cmd_unexpected", 64'(1), 64'(0));
            end else begin
                c = cmd_q.pop_front();
                check("cmd_data", 64'(cmd_data), 64'(c.data));
                check("cmd_len", 64'(cmd_len), 64'(c.len));
            end
        end
    end

    byte pool[16] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h29,8'h66,8'h5A,
                      8'h5A,8'hF0,8'hF0,8'hE0,8'h05,8'h45,8'h16,8'h75};

    initial begin
        do_reset();
        // two chars with breaks, then Enter
        foreach (pool[i]) if (i < 0) drive(1'b0, 8'h00, 1'b0);
        drive(1,8'h1C,0); drive(1,8'hF0,0); drive(1,8'h1C,0);
        drive(1,8'h32,0); drive(1,8'hF0,0); drive(1,8'h32,0); drive(1,8'h5A,0);
        drive(0,8'h00,1); drive(0,8'h00,0);
        // overflow, backspace, commit clears overflow
        press(8'h1C,0); press(8'h32,0); press(8'h21,0); press(8'h23,0); press(8'h24,0);
        drive(1,8'h66,0); drive(1,8'h5A,0); drive(0,8'h00,1);
        // extended make/break and unmapped code
        press(8'h1C,0);
        drive(1,8'hE0,0); drive(1,8'h75,0); drive(1,8'hE0,0); drive(1,8'hF0,0); drive(1,8'h75,0);
        drive(1,8'h05,0); drive(1,8'h32,0);
        drive(1,8'h66,0); drive(1,8'h66,0); drive(1,8'h66,0);
        // occupied slot holds; Enter with ready swaps in the new line
        press(8'h1C,0); drive(1,8'h5A,0);
        press(8'h32,0); drive(1,8'h5A,0); drive(0,8'h00,0);
        drive(1,8'h5A,1); drive(0,8'h00,1); drive(0,8'h00,0);
        // typematic repeat
        drive(1,8'h1C,0); drive(1,8'h1C,0); drive(1,8'h1C,0); drive(1,8'hF0,0); drive(1,8'h1C,0);
        drive(1,8'h5A,1); drive(0,8'h00,1);
        // reset mid-line, then F0 must start a break from IDLE
        press(8'h1C,0); press(8'h32,0);
        do_reset();
        drive(1,8'hF0,0); drive(1,8'h1C,0); drive(1,8'h32,0);
        // random traffic
        for (int n = 0; n < 800; n++)
            drive($urandom_range(0,3) != 0, pool[$urandom_range(0,15)], $urandom_range(0,1) == 1);
        for (int n = 0; n < 3; n++) drive(0, 8'h00, 1);
        for (int n = 0; n < 4 && exp_q.size() > 0; n++) @(negedge clk);
        #1;
        check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
        check("cmd_queue_drained", 64'(cmd_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
